// File: rtl/encoder_seq.sv
// Sequential line encoder: captures event pulses into sticky pending bits and
// presents them one at a time as a binary address over a valid/ready handshake.
module encoder_seq #(
  parameter int N    = 4,
  parameter int AW   = 2,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  D,
  output logic [AW-1:0] A,
  output logic          V,
  input  logic          R,
  output logic [N-1:0]  P,
  output logic          OVF
);

  logic [AW-1:0] r_a;
  logic          r_v;
  logic [N-1:0]  r_p;
  logic          r_ovf;
  logic [AW-1:0] r_last;

  logic          w_free;
  logic          w_load;
  logic [AW-1:0] w_sel;
  logic [N-1:0]  w_clear;
  logic [N-1:0]  w_p_next;
  logic          w_ovf_set;

  // Lowest set index; scanning downward lets the smallest index win.
  function automatic logic [AW-1:0] f_lowest(input logic [N-1:0] p);
    logic [AW-1:0] s;
    s = {AW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (p[i]) begin
        s = i[AW-1:0];
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  // First set index after last, wrapping; N is a power of two so AW-bit adds wrap.
  function automatic logic [AW-1:0] f_rr(input logic [N-1:0] p, input logic [AW-1:0] last);
    logic [AW-1:0] s;
    logic [AW-1:0] idx;
    s = {AW{1'b0}};
    for (int k = N; k >= 1; k--) begin
      idx = last + k[AW-1:0];
      if (p[idx]) begin
        s = idx;
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  // Slot/load decision, pending-bit update and overflow detection.
  always_comb begin
    w_free    = ~r_v | R;
    w_load    = w_free & (|r_p);
    w_sel     = (MODE == 1) ? f_rr(r_p, r_last) : f_lowest(r_p);
    w_clear   = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_clear[i] = w_load & (w_sel == i[AW-1:0]);
    end
    w_p_next  = (r_p & ~w_clear) | D;
    w_ovf_set = |(D & r_p & ~w_clear);
  end

  // State registers: output slot, pending bits, sticky overflow, RR pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= {AW{1'b0}};
      r_v    <= 1'b0;
      r_p    <= {N{1'b0}};
      r_ovf  <= 1'b0;
      r_last <= {AW{1'b1}};
    end else begin
      r_p <= w_p_next;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
      if (w_load) begin
        r_a    <= w_sel;
        r_v    <= 1'b1;
        r_last <= w_sel;
      end else if (w_free) begin
        r_v <= 1'b0;
      end
    end
  end

  assign A   = r_a;
  assign V   = r_v;
  assign P   = r_p;
  assign OVF = r_ovf;

endmodule

// File: tb/tb_encoder_seq.sv
// Bench for encoder_seq: one fixed-priority and one round-robin instance share
// stimulus and are checked against an event-level reference model.
module tb_encoder_seq;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  d;
  logic          r;
  logic [AW-1:0] a0, a1;
  logic          v0, v1, ovf0, ovf1;
  logic [N-1:0]  p0, p1;

  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 = fixed priority, 1 = round robin.
  int m_pend [2][N];
  int m_v    [2];
  int m_a    [2];
  int m_last [2];
  int m_ovf  [2];

  encoder_seq #(.N(N), .AW(AW), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .D(d), .A(a0), .V(v0), .R(r), .P(p0), .OVF(ovf0));
  encoder_seq #(.N(N), .AW(AW), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .D(d), .A(a1), .V(v1), .R(r), .P(p1), .OVF(ovf1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int m);
    int s;
    int clr;
    s   = -1;
    clr = -1;
    if (rst) begin
      for (int i = 0; i < N; i++) m_pend[m][i] = 0;
      m_v[m] = 0; m_a[m] = 0; m_ovf[m] = 0; m_last[m] = N - 1;
    end else begin
      if (!m_v[m] || r) begin
        if (m == 0) begin
          for (int i = 0; i < N && s < 0; i++) if (m_pend[m][i] != 0) s = i;
        end else begin
          for (int k = 1; k <= N && s < 0; k++)
            if (m_pend[m][(m_last[m] + k) % N] != 0) s = (m_last[m] + k) % N;
        end
        if (s >= 0) begin
          m_a[m] = s; m_v[m] = 1; m_last[m] = s; clr = s;
        end else begin
          m_v[m] = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (d[i] && m_pend[m][i] != 0 && i != clr) m_ovf[m] = 1;
        if (i == clr) m_pend[m][i] = 0;
        if (d[i]) m_pend[m][i] = 1;
      end
    end
  endtask

  function automatic int pend_vec(input int m);
    int pv;
    pv = 0;
    for (int i = 0; i < N; i++) if (m_pend[m][i] != 0) pv = pv | (1 << i);
    return pv;
  endfunction

  task automatic compare_all();
    chk("m0_V",   int'(v0),   m_v[0]);
    chk("m0_A",   int'(a0),   m_a[0]);
    chk("m0_P",   int'(p0),   pend_vec(0));
    chk("m0_OVF", int'(ovf0), m_ovf[0]);
    chk("m1_V",   int'(v1),   m_v[1]);
    chk("m1_A",   int'(a1),   m_a[1]);
    chk("m1_P",   int'(p1),   pend_vec(1));
    chk("m1_OVF", int'(ovf1), m_ovf[1]);
  endtask

  // Apply inputs for one edge, advance the model, then sample after the edge.
  task automatic step(input logic [N-1:0] dv, input logic rv, input logic rs);
    d = dv; r = rv; rst = rs;
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    d = 4'b0000; r = 1'b1; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < N; j++) m_pend[i][j] = 0;
      m_v[i] = 0; m_a[i] = 0; m_last[i] = N - 1; m_ovf[i] = 0;
    end

    // Reset with D active; D must be ignored.
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    chk("rst_V", int'(v0), 0);
    chk("rst_P", int'(p0), 0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("idle_V", int'(v1), 0);

    // Single event on line 2.
    step(4'b0100, 1'b1, 1'b0);
    chk("single_P", int'(p0), 4);
    step(4'b0000, 1'b1, 1'b0);
    chk("single_A", int'(a0), 2);
    chk("single_V", int'(v0), 1);
    step(4'b0000, 1'b1, 1'b0);
    chk("single_Voff", int'(v0), 0);

    // Fixed priority drain of 1011.
    step(4'b1011, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0); chk("fp_A0", int'(a0), 0);
    step(4'b0000, 1'b1, 1'b0); chk("fp_A1", int'(a0), 1);
    step(4'b0000, 1'b1, 1'b0); chk("fp_A3", int'(a0), 3);
    step(4'b0000, 1'b1, 1'b0); chk("fp_Voff", int'(v0), 0);

    // Backpressure and overflow on line 0.
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0); chk("bp_V", int'(v0), 1);
    step(4'b0001, 1'b0, 1'b0); chk("bp_P", int'(p0), 1);
    chk("bp_OVF0", int'(ovf0), 0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0); chk("bp_OVF1", int'(ovf0), 1);
    step(4'b0000, 1'b1, 1'b0); chk("bp_A2nd", int'(a0), 0);
    step(4'b0000, 1'b1, 1'b0); chk("bp_Voff", int'(v0), 0);
    chk("bp_OVF_sticky", int'(ovf0), 1);

    // Round robin versus fixed priority with 1001 held.
    step(4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(4'b1001, 1'b1, 1'b0);
    chk("rr_OVF", int'(ovf1), 1);
    chk("fp_hold_A", int'(a0), 0);

    // Simultaneous load and set on line 2.
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    chk("sim_A", int'(a0), 2);
    chk("sim_P", int'(p0), 4);
    step(4'b0000, 1'b1, 1'b0);
    chk("sim_A2", int'(a0), 2);
    chk("sim_OVF", int'(ovf0), 0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom & $urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/encoder_seq.md
Name: encoder_seq

Overview:
Sequential counterpart of the 2-to-4 line decoder. It captures event pulses on N decoded lines into sticky pending bits and encodes them one at a time back into an AW-bit line address. Each address is presented with a valid/ready handshake, so a downstream consumer can drain events at its own rate. It sits on the return path wherever a set of one-hot or multi-hot lines must be reduced to a binary index, such as interrupt or request collection.

Parameters:
N, 4, number of decoded input lines; must equal 2**AW; N >= 2
AW, 2, width of the encoded address output
MODE, 0, selection policy: 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
D  input  N  event lines; D[i]=1 in a cycle posts one event on line i
A  output  AW  encoded address of the presented event
V  output  1  A is valid
R  input  1  consumer ready; transfer occurs on an edge where V=1 and R=1
P  output  N  pending bits (events captured, not yet loaded to A)
OVF  output  1  sticky overflow: an event merged into an already pending bit

Behaviour:
- Reset: synchronous, active-high.
  - On any edge with rst=1: A=0, V=0, P=0, OVF=0. Round-robin pointer LAST is set to N-1, so the first search starts at index 0.
  - D is ignored on reset edges.
  - Reset mid-transfer discards the presented event and all pending events.
- Output slot is free on an edge when V=0 or (V=1 and R=1).
- Load, at each non-reset edge where the slot is free:
  - If P != 0: select index s from P. Do not include same-cycle D.
  - Then A<=s, V<=1, clear P[s], and set LAST<=s.
  - If P == 0: V<=0. A holds its last value; don't care while V=0.
- Hold: while V=1 and R=0, A and V are stable and no load occurs.
- Capture, every non-reset edge: P_next = (P & ~load_clear) | D.
  - Set wins over clear. If D[s]=1 on the edge that loads s, P[s] stays 1 as a second event.
- Overflow: OVF<=1 on an edge where D[i]=1 and P[i]=1 and bit i is not being cleared by a load that edge. Only rst clears OVF.
- Selection:
  - MODE=0: s = lowest set index of P.
  - MODE=1: s = first set index scanning LAST+1, LAST+2, … mod N (wrap-around).
- Latency:
  - D[i] sampled at edge e0 makes P[i]=1 after e0.
  - With the slot free, A=i and V=1 appear after e0+1 (two edges from the D cycle).
  - Back-to-back loads are possible every cycle with R held at 1: one event per cycle throughput.
- A is a registered output. P, V and OVF are also registers; no combinational path from D or R to any output.
- Events are counted at most once per pending bit plus one in the output slot. Excess events are lost and flagged by OVF.

Test Plan:
- Reset: rst=1 for 2 edges with D=1111, R=1 -> after release V=0, A=0, P=0000, OVF=0. With D=0 thereafter, V stays 0.
- Single event: D=0100 for one cycle, R=1 -> P=0100 after the 1st edge; V=1, A=2 after the 2nd edge for exactly one cycle; P=0000; then V=0.
- Fixed priority (MODE=0): D=1011 one cycle, R=1 -> A sequence 0, 1, 3 on consecutive cycles with V=1 for 3 cycles; then V=0, OVF=0.
- Backpressure and overflow: R=0.
  - D=0001 pulse -> V=1, A=0, held.
  - Second D=0001 pulse -> P=0001, OVF=0.
  - Third pulse -> OVF=1.
  - Then R=1 -> transfers A=0 twice (slot, then pending), then V=0. OVF stays 1 until rst.
- Round-robin (MODE=1): D=1001 held every cycle, R=1 -> A alternates 0, 3, 0, 3 … and OVF becomes 1.
  - Same stimulus with MODE=0 -> A=0 every cycle.
- Simultaneous load and set: P=0100, slot free, D=0100 on the loading edge -> A=2 that edge and P stays 0100. Next edge A=2 again with V=1; OVF=0.
